// File: rtl/led_racer_pkg.sv
// rtl/led_racer_pkg.sv - shared WS2812 timing defaults, transmitter FSM states and colour packing
package led_racer_pkg;

    localparam int T_BIT_DEFAULT        = 62;
    localparam int T0H_DEFAULT          = 20;
    localparam int T1H_DEFAULT          = 40;
    localparam int RESET_CYCLES_DEFAULT = 2500;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        LATCH
    } tx_state_t;

    typedef enum logic [1:0] {
        ORDER_GRB,
        ORDER_RGB,
        ORDER_BRG
    } colour_order_t;

    localparam colour_order_t COLOUR_ORDER = ORDER_GRB;

    typedef logic [23:0] colour_t;

    // Wire order of the strip; dim drops the two LSBs of every channel.
    function automatic colour_t pack_colour(input logic [7:0] g, input logic [7:0] r,
                                            input logic [7:0] b, input logic dim);
        logic [7:0] gd, rd, bd;
        gd = dim ? {2'b00, g[7:2]} : g;
        rd = dim ? {2'b00, r[7:2]} : r;
        bd = dim ? {2'b00, b[7:2]} : b;
        case (COLOUR_ORDER)
            ORDER_GRB: return {gd, rd, bd};
            ORDER_RGB: return {rd, gd, bd};
            default:   return {bd, rd, gd};
        endcase
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// rtl/ws2812_bit_encoder.sv - one WS2812 bit period: bit timer and high-time compare
module ws2812_bit_encoder
    import led_racer_pkg::*;
#(
    parameter int T_BIT = T_BIT_DEFAULT,
    parameter int T0H   = T0H_DEFAULT,
    parameter int T1H   = T1H_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_val,
    output logic bit_done,
    output logic data_out
);

    localparam int TIMER_W = $clog2(T_BIT);

    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] high_last;
    logic               active;

    assign high_last = bit_val ? TIMER_W'(T1H - 1) : TIMER_W'(T0H - 1);
    assign bit_done  = active && (timer == TIMER_W'(T_BIT - 1));

    // start arrives the cycle before a bit, so data_out rises with the first bit cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer    <= '0;
            active   <= 1'b0;
            data_out <= 1'b0;
        end else if (start) begin
            timer    <= '0;
            active   <= 1'b1;
            data_out <= 1'b1;
        end else if (bit_done) begin
            timer    <= '0;
            active   <= 1'b0;
            data_out <= 1'b0;
        end else if (active) begin
            timer    <= timer + TIMER_W'(1);
            data_out <= (timer < high_last);
        end else begin
            data_out <= 1'b0;
        end
    end

endmodule

// File: rtl/ws2812_frame_tx.sv
// rtl/ws2812_frame_tx.sv - WS2812 frame transmitter; WS2812_FRAME_TX_DIM_EN selects quarter brightness
module ws2812_frame_tx
    import led_racer_pkg::*;
#(
    parameter int MAX_POS      = 109,
    parameter int T_BIT        = T_BIT_DEFAULT,
    parameter int T0H          = T0H_DEFAULT,
    parameter int T1H          = T1H_DEFAULT,
    parameter int RESET_CYCLES = RESET_CYCLES_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    output logic [$clog2(MAX_POS)-1:0] current_led,
    input  logic [7:0]                 led_green_intensity,
    input  logic [7:0]                 led_red_intensity,
    input  logic [7:0]                 led_blue_intensity,
    output logic                       data_out,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int LED_W   = $clog2(MAX_POS);
    localparam int LATCH_W = $clog2(RESET_CYCLES + 1);
    localparam logic [LED_W-1:0] LAST_LED = LED_W'(MAX_POS - 1);

`ifdef WS2812_FRAME_TX_DIM_EN
    localparam logic DIM = 1'b1;
`else
    localparam logic DIM = 1'b0;
`endif

    tx_state_t          state;
    colour_t            shift_reg;
    colour_t            captured;
    logic [4:0]         bit_idx;
    logic [LATCH_W-1:0] latch_cnt;
    logic               bit_done;
    logic               enc_start;
    logic               last_bit;

    assign captured  = pack_colour(led_green_intensity, led_red_intensity, led_blue_intensity, DIM);
    assign last_bit  = (bit_idx == 5'd23);
    assign enc_start = (state == LOAD) || ((state == SEND) && bit_done && !last_bit);

    ws2812_bit_encoder #(
        .T_BIT (T_BIT),
        .T0H   (T0H),
        .T1H   (T1H)
    ) u_bit_encoder (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (enc_start),
        .bit_val  (shift_reg[23]),
        .bit_done (bit_done),
        .data_out (data_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            current_led <= '0;
            shift_reg   <= '0;
            bit_idx     <= '0;
            latch_cnt   <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    current_led <= '0;
                    if (enable) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    shift_reg <= captured;
                    bit_idx   <= '0;
                    state     <= SEND;
                end
                SEND: begin
                    if (bit_done) begin
                        shift_reg <= {shift_reg[22:0], 1'b0};
                        if (!last_bit) begin
                            bit_idx <= bit_idx + 5'd1;
                        end else if (current_led == LAST_LED) begin
                            state      <= LATCH;
                            latch_cnt  <= '0;
                            frame_done <= (RESET_CYCLES == 1);
                        end else begin
                            current_led <= current_led + LED_W'(1);
                            state       <= LOAD;
                        end
                    end
                end
                LATCH: begin
                    // frame_done is registered one count early so it lands on the final gap cycle
                    if (latch_cnt == LATCH_W'(RESET_CYCLES - 1)) begin
                        latch_cnt   <= '0;
                        current_led <= '0;
                        busy        <= enable;
                        state       <= enable ? LOAD : IDLE;
                    end else begin
                        latch_cnt  <= latch_cnt + LATCH_W'(1);
                        frame_done <= (latch_cnt == LATCH_W'(RESET_CYCLES - 2));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ws2812_frame_tx.md
# ws2812_frame_tx

Serial transmitter for the LED strip. It walks `current_led` from 0 to MAX_POS-1 and samples the 24-bit colour that the screen compositor returns combinationally for each index. Each colour is serialised as a WS2812 one-wire bit stream in GRB order, MSB first, and every frame ends with a latch/reset gap. The block sits between the `screens` compositor and the strip data pin.

## Interface
Parameters:
- `MAX_POS`, 109: number of LEDs per frame.
- `T_BIT`, 62: clock cycles per encoded bit (1.25 µs at 50 MHz).
- `T0H`, 20: high cycles for a 0 bit. Requires 0 < T0H < T1H < T_BIT.
- `T1H`, 40: high cycles for a 1 bit.
- `RESET_CYCLES`, 2500: low cycles of the latch gap after the last LED (50 µs).

Ports:
- `clk` in 1: single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: request continuous frame transmission.
- `current_led` out $clog2(MAX_POS): LED index presented to the compositor.
- `led_green_intensity` in 8: compositor green for `current_led`.
- `led_red_intensity` in 8: compositor red.
- `led_blue_intensity` in 8: compositor blue.
- `data_out` out 1: strip data line.
- `busy` out 1: high from leaving IDLE until the frame's latch gap ends.
- `frame_done` out 1: one-cycle pulse on the last cycle of each latch gap.

## Operation
- Reset values: `current_led`=0, `data_out`=0, `busy`=0, `frame_done`=0, state IDLE, all counters 0.
- FSM states: IDLE, LOAD, SEND, LATCH.
- IDLE: `current_led` is held at 0. When `enable`=1, go to LOAD.
- LOAD (1 cycle): capture {G,R,B} into a 24-bit shift register, clear the bit counter, go to SEND. The index was already stable for at least 1 cycle, so the compositor output has settled.
- SEND: emit the shift register MSB using the bit encoder. After the T_BIT-th cycle of a bit, shift left.
  - After bit 23 of LED n < MAX_POS-1: increment `current_led` and go to LOAD.
  - After bit 23 of LED MAX_POS-1: go to LATCH.
- LATCH: hold `data_out`=0 for RESET_CYCLES cycles and pulse `frame_done` on the last one.
  - Then, if `enable`=1: `current_led`←0, go to LOAD (back-to-back frames).
  - Otherwise: `current_led`←0, go to IDLE.
- If `enable` falls mid-frame, the current frame and its latch complete. Frames are never truncated.
- Bit encoding: `data_out`=1 for cycles 0..T0H-1 (bit 0) or 0..T1H-1 (bit 1) of the bit period, and 0 for the rest of the T_BIT cycles.
- Counter widths: bit timer $clog2(T_BIT), bit index 5 bits, latch counter $clog2(RESET_CYCLES+1). The index counter never exceeds MAX_POS-1, so no wrap is possible.
- An asynchronous reset mid-bit forces `data_out` low immediately. The strip sees an aborted frame; the next frame starts from LED 0.

## Timing
- With `enable` sampled high in IDLE at edge k: LOAD at k+1, first `data_out` rise at k+2.
- A bit period is exactly T_BIT cycles. One LED takes 24·T_BIT cycles plus 1 LOAD cycle.
- Whole frame from the first rise to the `frame_done` pulse: MAX_POS·(24·T_BIT+1) − 1 + RESET_CYCLES cycles.
- `current_led` changes only on the SEND→LOAD transition and when leaving LATCH.
- `data_out` is driven from a flop, so it has no glitches.

## Configuration
- `WS2812_FRAME_TX_DIM_EN` defined: each captured channel is shifted right by 2, giving quarter brightness to limit strip current. The low 2 bits of each sampled intensity are discarded and zeros enter at the MSB.
- Not defined: channels are transmitted exactly as received.
- Timing is identical in both builds.

## Structure
- Shared package `led_racer_pkg`:
  - timing defaults (T_BIT, T0H, T1H, RESET_CYCLES at 50 MHz);
  - the FSM state enum;
  - the colour-order constant (GRB) and the 24-bit colour typedef.
- Sub-module `ws2812_bit_encoder`: holds the bit timer and high-time compare. It takes `start`/`bit_val` and returns `bit_done` and `data_out`.

## Test plan
Bench parameters: MAX_POS=3, T_BIT=10, T0H=3, T1H=7, RESET_CYCLES=20.
- Reset, then `enable`=0 for 50 cycles -> `data_out`=0, `busy`=0, `current_led`=0 throughout.
- Compositor model returns G=0xFF, R=0x00, B=0xA5 for every index; pulse `enable` high -> first rise 2 cycles after `enable` is sampled. The first 8 bits are 7-cycle highs, the next 8 are 3-cycle highs, and B decodes as 1010_0101.
- Colour = index·0x10 per channel; `enable` held high -> `current_led` steps 0,1,2 every 241 cycles. The decoded stream matches per LED, `frame_done` pulses once 20 latch cycles after the last bit, and the second frame begins with LOAD on the next cycle.
- Drop `enable` during LED 1 -> LEDs 1 and 2 still sent, latch completes, `frame_done` pulses, FSM returns to IDLE, `current_led`=0.
- Assert `rst_n`=0 mid-bit while `data_out`=1 -> `data_out` goes 0 without waiting for a clock edge, all outputs at reset values. After release with `enable`=1, the frame restarts at LED 0.
- Build with `WS2812_FRAME_TX_DIM_EN`, input G=R=B=0xFF -> each decoded channel is 0x3F.
